// File: rtl/mem_if.sv
// mem_if -- word bus between the load/store unit and memory.
//   MemReq    : access request, held until MemReady
//   MemWE     : 1 = write
//   MemAddr   : word-aligned byte address
//   MemWData  : lane-replicated write data
//   MemByteEn : per-byte write/read enables
//   MemReady  : memory completes the access this cycle
//   MemRData  : read data, valid with MemReady
interface mem_if;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteEn;
  logic        MemReady;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData, MemByteEn,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData, MemByteEn,
    output MemReady, MemRData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit -- turns decoder load/store requests into single bus
// transactions, stalling the core until the bus completes.
//   clk, reset        : clock, synchronous active-high reset
//   MemEn, MemWrite   : access request / store select from the decoder
//   Funct3            : size and signedness (B/H/W, BU/HU)
//   Addr, StoreData   : byte address and right-aligned store value
//   Stall             : hold the core's PC and pipeline
//   LoadData          : aligned, extended result of the last completed load
//   Misaligned        : pulse when an access is rejected for alignment
//   BusError          : pulse when the bus wait limit expires
//   bus               : mem_if master
// WAIT_LIMIT bounds the number of BUSY cycles (0 = wait forever).
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemEn,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        Misaligned,
  output logic        BusError,
  mem_if.master       bus
);

  // Counter only needs to reach WAIT_LIMIT-1: the abort decision is made
  // in the last allowed BUSY cycle.
  localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic        req_q, we_q, berr_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, ld_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [CW-1:0] cnt_q;

  logic        is_w, is_h, aligned, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Funct3[1] set means word; this also folds 011/110/111 into W.
  assign is_w = Funct3[1];
  assign is_h = ~Funct3[1] & Funct3[0];
  assign aligned = is_w ? (Addr[1:0] == 2'b00) : (is_h ? ~Addr[0] : 1'b1);

  always_comb begin
    be_d    = 4'b0001 << Addr[1:0];
    wdata_d = {4{StoreData[7:0]}};
    if (is_h) begin
      be_d    = 4'b0011 << {Addr[1], 1'b0};
      wdata_d = {2{StoreData[15:0]}};
    end
    if (is_w) begin
      be_d    = 4'b1111;
      wdata_d = StoreData;
    end
  end

  // Lane select uses the offset captured with the request, not the live Addr.
  always_comb begin
    lane_b = bus.MemRData[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];
    ld_d   = bus.MemRData;
    case (f3_q)
      3'b000:  ld_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_d = {24'b0, lane_b};
      3'b001:  ld_d = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_d = {16'b0, lane_h};
      default: ld_d = bus.MemRData;
    endcase
  end

  assign timeout = (WAIT_LIMIT != 0) && (cnt_q == LIM_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      ld_q    <= '0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      berr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemEn && aligned) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= MemWrite;
            addr_q  <= {Addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= Addr[1:0];
            f3_q    <= Funct3;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // A response in the last allowed cycle still wins over the abort.
          if (bus.MemReady) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) ld_q <= ld_d;
          end else if (timeout) begin
            req_q   <= 1'b0;
            berr_q  <= 1'b1;
            state_q <= DONE;
          end else if (WAIT_LIMIT != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall releases in the misaligned cycle so the core can take the trap.
  assign Stall      = (state_q == BUSY) || ((state_q == IDLE) && MemEn && aligned);
  assign Misaligned = ~reset && (state_q == IDLE) && MemEn && ~aligned;
  assign BusError   = berr_q;
  assign LoadData   = ld_q;

  assign bus.MemReq    = req_q;
  assign bus.MemWE     = we_q;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWData  = wdata_q;
  assign bus.MemByteEn = be_q;

endmodule
